// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the multi-cycle memory responder.
// State encodings, default geometry/latency, and the request-check helper live here.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MEMR_IDLE = 2'd0,
    MEMR_WAIT = 2'd1,
    MEMR_RESP = 2'd2
  } memr_state_e;

  localparam int unsigned MEM_LATENCY_DEF = 2;
  localparam int unsigned MEM_DEPTH_DEF   = 1024;
  localparam int unsigned MEM_CNT_W       = 4;

  // A request is rejected when misaligned, beyond the array, or carrying both strobes.
  function automatic logic req_err(input logic        rd,
                                   input logic        wr,
                                   input logic [31:0] addr,
                                   input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0) || (rd && wr);
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Synchronous single-port word RAM holding both instructions and data.
// Contents are deliberately not reset; read data appears one cycle after ridx.
module mem_responder_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] widx_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] ridx_i,
  output logic [31:0]   rdata_raw_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_raw_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
    rdata_raw_q <= mem_q[ridx_i];
  end

  assign rdata_raw_o = rdata_raw_q;

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory slave: latches one request, waits LATENCY cycles, then pulses mem_ready_o.
// Handshake: the initiator holds mem_read_i/mem_write_i until it sees the one-cycle mem_ready_o pulse.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = MEM_DEPTH_DEF,
  parameter int unsigned LATENCY     = MEM_LATENCY_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        mem_ready_o,
  output logic        mem_err_o,
  output logic        busy_o,
  output logic [1:0]  state_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  memr_state_e          state_q, state_d;
  logic [MEM_CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]        widx_q, widx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 is_write_q, is_write_d;
  logic                 req_err_q, req_err_d;
  logic                 resp_q;
  logic                 ready_q;
  logic                 err_q;
  logic [31:0]          rdata_q;

  logic                 enter_resp;
  logic                 arr_we;
  logic [AW-1:0]        arr_ridx;
  logic [31:0]          rdata_raw;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    req_err_d  = req_err_q;
    case (state_q)
      MEMR_IDLE: begin
        // resp_q blocks the strobes the initiator is still holding from the last transaction.
        if ((mem_read_i || mem_write_i) && !resp_q) begin
          widx_d     = addr_i[AW+1:2];
          wdata_d    = wdata_i;
          is_write_d = mem_write_i;
          req_err_d  = req_err(mem_read_i, mem_write_i, addr_i, AW);
          cnt_d      = MEM_CNT_W'(LATENCY - 1);
          state_d    = MEMR_WAIT;
        end
      end
      MEMR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = MEMR_RESP;
        end else begin
          cnt_d = cnt_q - MEM_CNT_W'(1);
        end
      end
      MEMR_RESP: state_d = MEMR_IDLE;
      default:   state_d = MEMR_IDLE;
    endcase
  end

  assign enter_resp = (state_q == MEMR_WAIT) && (cnt_q == '0);

  // The RAM index follows the bus while idle so read data is already registered by the last WAIT cycle.
  assign arr_ridx = (state_q == MEMR_IDLE) ? addr_i[AW+1:2] : widx_q;
  assign arr_we   = (state_q == MEMR_RESP) && is_write_q && !req_err_q;

  mem_responder_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk_i       (clk_i),
    .we_i        (arr_we),
    .widx_i      (widx_q),
    .wdata_i     (wdata_q),
    .ridx_i      (arr_ridx),
    .rdata_raw_o (rdata_raw)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= MEMR_IDLE;
      cnt_q      <= '0;
      widx_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      req_err_q  <= 1'b0;
      resp_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      req_err_q  <= req_err_d;
      resp_q     <= (state_q == MEMR_RESP);
      ready_q    <= enter_resp;
      err_q      <= enter_resp && req_err_q;
      if (enter_resp && !is_write_q && !req_err_q) begin
        rdata_q <= rdata_raw;
      end
    end
  end

  assign rdata_o     = rdata_q;
  assign mem_ready_o = ready_q;
  assign mem_err_o   = err_q;
  assign busy_o      = (state_q != MEMR_IDLE);
  assign state_o     = state_q;

endmodule
